sub_seq_ctrl: RTL and testbench

//   Sequencer for multi-precision subtraction on one narrow subtract slice.

---
 rtl/sub_seq_ctrl.sv | 87 ++++++++
 tb/tb_sub_seq_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sub_seq_ctrl.sv
// sub_seq_ctrl: multi-cycle WIDTH-bit subtract a - b - bin on a SLICE-bit slice, LSB slice first,
// with valid/ready handshakes on operand and result sides.
module sub_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout,
  output logic             out_zero,
  output logic             busy
);
  localparam int NSTEP = WIDTH / SLICE;
  localparam int SW = NSTEP > 1 ? $clog2(NSTEP) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q;
  logic [SW-1:0]    step_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q, diff_d;
  logic             borrow_q, in_ready_q, out_valid_q, busy_q, zero_q;
  logic [SLICE:0]   sub_d;
  logic             last_d;
  always_comb begin
    sub_d  = {1'b0, a_q[step_q*SLICE +: SLICE]} - {1'b0, b_q[step_q*SLICE +: SLICE]}
             - {{SLICE{1'b0}}, borrow_q};
    diff_d = diff_q;
    diff_d[step_q*SLICE +: SLICE] = sub_d[SLICE-1:0];
    last_d = step_q == SW'(NSTEP - 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q        <= in_a;
          b_q        <= in_b;
          borrow_q   <= in_bin;
          step_q     <= '0;
          diff_q     <= '0;
          state_q    <= RUN;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
        end
        RUN: begin
          diff_q   <= diff_d;
          borrow_q <= sub_d[SLICE];
          step_q   <= last_d ? '0 : step_q + 1'b1;
          if (last_d) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            zero_q      <= diff_d == '0;
          end
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_diff  = diff_q;
  assign out_bout  = borrow_q;
  assign out_zero  = zero_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_sub_seq_ctrl.sv
// tb_sub_seq_ctrl: directed and randomized checks of sub_seq_ctrl against an arithmetic model.
module tb_sub_seq_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_bin = 1'b0;
  logic [15:0] in_a = '0, in_b = '0, out_diff;
  logic        out_valid, out_ready = 1'b0, out_bout, out_zero, busy;
  int          n_chk = 0, n_pass = 0;
  typedef struct packed {logic [15:0] diff; logic bout; logic zero;} res_t;
  res_t        sb[$];
  sub_seq_ctrl #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_bin(in_bin), .out_valid(out_valid),
    .out_ready(out_ready), .out_diff(out_diff), .out_bout(out_bout),
    .out_zero(out_zero), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] full;
    full = {1'b0, a} - {1'b0, b} - 17'(bin);
    return '{diff: full[15:0], bout: full[16], zero: full[15:0] == 16'h0};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle_reset(input string tag);
    check({tag, ".in_ready"}, in_ready, 1);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".diff"}, out_diff, 0);
    check({tag, ".bout"}, out_bout, 0);
    check({tag, ".zero"}, out_zero, 0);
    check({tag, ".busy"}, busy, 0);
  endtask
  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick;
      lat++;
    end
    if (!out_valid) check({tag, ".timeout"}, 0, 1);
  endtask
  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin);
    res_t e;
    int   lat;
    e = model(a, b, bin);
    in_a = a; in_b = b; in_bin = bin; in_valid = 1'b1; out_ready = 1'b0;
    check({tag, ".ready"}, in_ready, 1);
    tick;
    in_valid = 1'b0; in_a = ~a; in_b = ~b; in_bin = ~bin;
    check({tag, ".busy"}, busy, 1);
    wait_valid(tag, lat);
    check({tag, ".latency"}, lat, 4);
    check({tag, ".diff"}, out_diff, e.diff);
    check({tag, ".bout"}, out_bout, e.bout);
    check({tag, ".zero"}, out_zero, e.zero);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, ".drained"}, out_valid, 0);
    check({tag, ".idle"}, in_ready, 1);
  endtask
  initial begin
    res_t e, e2;
    int   lat, acc, got, cyc;
    logic fired_in, fired_out;
    #12;
    check_idle_reset("rst0");
    @(negedge clk) rst = 1'b0;
    tick;
    in_a = 16'h5555; in_b = 16'h1111; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    #2;
    check_idle_reset("rst_run");
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      check("rst_run.no_valid", out_valid, 0);
      check("rst_run.ready", in_ready, 1);
    end
    directed("t2", 16'h1234, 16'h0234, 1'b0);
    directed("t3", 16'h0000, 16'h0001, 1'b0);
    directed("t4", 16'h8000, 16'h7FFF, 1'b1);
    directed("t4b", 16'hFFFF, 16'hFFFF, 1'b1);
    e = model(16'hA5A5, 16'h0F0F, 1'b1);
    e2 = model(16'h0003, 16'h0004, 1'b0);
    in_a = 16'hA5A5; in_b = 16'h0F0F; in_bin = 1'b1; in_valid = 1'b1;
    tick;
    in_a = 16'h0003; in_b = 16'h0004; in_bin = 1'b0;
    wait_valid("t5", lat);
    for (int i = 0; i < 10; i++) begin
      check("t5.valid", out_valid, 1);
      check("t5.ready", in_ready, 0);
      check("t5.diff", out_diff, e.diff);
      check("t5.bout", out_bout, e.bout);
      tick;
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("t5.idle", in_ready, 1);
    tick;
    in_valid = 1'b0;
    wait_valid("t5b", lat);
    check("t5b.latency", lat, 4);
    check("t5b.diff", out_diff, e2.diff);
    check("t5b.bout", out_bout, e2.bout);
    check("t5b.zero", out_zero, e2.zero);
    out_ready = 1'b1;
    tick;
    acc = 0; got = 0; cyc = 0;
    while (got < 1000 && cyc < 60000) begin
      if (acc < 1000) begin
        in_valid = $urandom_range(0, 3) != 0;
        in_a = 16'($urandom);
        in_b = $urandom_range(0, 7) == 0 ? in_a : 16'($urandom);
        in_bin = 1'($urandom);
      end else in_valid = 1'b0;
      out_ready = $urandom_range(0, 1) == 1;
      fired_in = in_valid && in_ready;
      fired_out = out_valid && out_ready;
      if (fired_out) begin
        if (sb.size() == 0) check("rnd.spurious", 1, 0);
        else begin
          e = sb.pop_front();
          check("rnd.diff", out_diff, e.diff);
          check("rnd.bout", out_bout, e.bout);
          check("rnd.zero", out_zero, e.zero);
          got++;
        end
      end
      if (fired_in) begin
        sb.push_back(model(in_a, in_b, in_bin));
        acc++;
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0;
    check("rnd.count", got, 1000);
    check("rnd.leftover", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
